// File: rtl/imsic_pkg.sv
// Shared IMSIC/APLIC types: configuration records,
// MSI request record and the AXI master bundles.
package imsic_pkg;

  typedef struct packed {
    logic [63:0] InptFilesMAddr;
    logic [63:0] InptFilesSAddr;
    int          NrHarts;
    int          NrHartsW;
    int          NrInptFiles;
    int          NrSourcesW;
  } imsic_cfg_t;

  localparam imsic_cfg_t DefaultImsicCfg = '{
    InptFilesMAddr: 64'h2400_0000,
    InptFilesSAddr: 64'h2800_0000,
    NrHarts:        2,
    NrHartsW:       2,
    NrInptFiles:    3,
    NrSourcesW:     11
  };

  typedef struct packed {
    int AXI_ADDR_WIDTH;
    int AXI_DATA_WIDTH;
    int AXI_ID_WIDTH;
  } imsic_protocol_cfg_t;

  localparam imsic_protocol_cfg_t DefaultImsicProtocolCfg = '{
    AXI_ADDR_WIDTH: 64,
    AXI_DATA_WIDTH: 64,
    AXI_ID_WIDTH:   4
  };

  localparam int AXI_AW = DefaultImsicProtocolCfg.AXI_ADDR_WIDTH;
  localparam int AXI_DW = DefaultImsicProtocolCfg.AXI_DATA_WIDTH;
  localparam int AXI_IW = DefaultImsicProtocolCfg.AXI_ID_WIDTH;

  localparam logic [31:0] MSI_FILE_STRIDE = 32'h1000;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;

  localparam int MSI_HART_W = DefaultImsicCfg.NrHartsW;
  localparam int MSI_FILE_W = $clog2(DefaultImsicCfg.NrInptFiles);
  localparam int MSI_EIID_W = DefaultImsicCfg.NrSourcesW;

  typedef struct packed {
    logic [MSI_HART_W-1:0] hart;
    logic [MSI_FILE_W-1:0] file;
    logic [MSI_EIID_W-1:0] eiid;
  } msi_req_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [AXI_DW-1:0]   data;
    logic [AXI_DW/8-1:0] strb;
    logic                last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [1:0]        resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_DW-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_mst_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_mst_resp_t;

endpackage

// File: rtl/aplic_msi_fifo.sv
// Power-of-two request queue for pending MSIs.
// Pointers wrap; the count has one spare bit for full.
module aplic_msi_fifo
  import imsic_pkg::*;
#(
  parameter int  Depth = 4,
  parameter type T     = msi_req_t
) (
  input  logic i_clk,
  input  logic ni_rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int PW = $clog2(Depth);

  T               mem_q [Depth];
  logic [PW-1:0]  wr_q;
  logic [PW-1:0]  rd_q;
  logic [PW:0]    cnt_q;
  logic           push_ok;
  logic           pop_ok;

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_full  = (cnt_q == (PW+1)'(Depth));
  assign o_empty = (cnt_q == '0);
  assign o_data  = mem_q[rd_q];

  // pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // entry storage
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_q] <= i_data;
    end
  end

endmodule

// File: rtl/aplic_msi_tx.sv
// MSI write initiator: queues APLIC MSI requests and
// posts each as one AXI write to the IMSIC seteipnum_le.
module aplic_msi_tx
  import imsic_pkg::*;
#(
  parameter imsic_cfg_t          ImsicCfg    = DefaultImsicCfg,
  parameter imsic_protocol_cfg_t ProtocolCfg = DefaultImsicProtocolCfg,
  parameter type                 axi_req_t   = axi_mst_req_t,
  parameter type                 axi_resp_t  = axi_mst_resp_t,
  parameter int                  FifoDepth   = 4
) (
  input  logic                                  i_clk,
  input  logic                                  ni_rst,
  input  logic                                  i_msi_valid,
  output logic                                  o_msi_ready,
  input  logic [ImsicCfg.NrHartsW-1:0]          i_msi_hart,
  input  logic [$clog2(ImsicCfg.NrInptFiles)-1:0] i_msi_file,
  input  logic [ImsicCfg.NrSourcesW-1:0]        i_msi_eiid,
  output axi_req_t                              o_req,
  input  axi_resp_t                             i_resp,
  output logic                                  o_busy,
  output logic                                  o_err
);

  localparam int AW = ProtocolCfg.AXI_ADDR_WIDTH;
  localparam int DW = ProtocolCfg.AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [SW-1:0] WSTRB = SW'(4'hF);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_e;

  state_e        state_q, state_d;
  logic          aw_pend_q, aw_pend_d;
  logic          w_pend_q, w_pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q;
  logic          live_q;

  logic          push_fire;
  logic          tgt_bad;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  msi_req_t      in_req;
  msi_req_t      head;
  logic [AW-1:0] addr_c;
  logic          b_err;
  logic          unused_resp;

  assign unused_resp = ^{i_resp.ar_ready, i_resp.r_valid,
                         i_resp.r, i_resp.b.id};

  assign o_msi_ready = live_q && !fifo_full;
  assign push_fire   = i_msi_valid && o_msi_ready;
  assign tgt_bad     = (int'(i_msi_hart) >= ImsicCfg.NrHarts)
                    || (int'(i_msi_file) >= ImsicCfg.NrInptFiles);
  assign fifo_push   = push_fire && !tgt_bad
                    && (i_msi_eiid != '0);

  assign in_req.hart = i_msi_hart;
  assign in_req.file = i_msi_file;
  assign in_req.eiid = i_msi_eiid;

  assign o_busy = !fifo_empty || (state_q != IDLE);
  assign o_err  = err_q;

  aplic_msi_fifo #(
    .Depth (FifoDepth),
    .T     (msi_req_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .ni_rst  (ni_rst),
    .i_push  (fifo_push),
    .i_data  (in_req),
    .i_pop   (fifo_pop),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // seteipnum_le address of the file named by the queue head
  always_comb begin
    if (head.file == '0) begin
      addr_c = AW'(ImsicCfg.InptFilesMAddr)
             + AW'(head.hart) * AW'(MSI_FILE_STRIDE);
    end else begin
      addr_c = AW'(ImsicCfg.InptFilesSAddr)
             + (AW'(head.hart) * AW'(ImsicCfg.NrInptFiles - 1)
                + AW'(head.file) - AW'(1))
             * AW'(MSI_FILE_STRIDE);
    end
  end

  // transaction sequencing: pop, issue AW+W, wait B
  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    addr_d    = addr_q;
    data_d    = data_q;
    fifo_pop  = 1'b0;
    b_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          addr_d    = addr_c;
          data_d    = DW'(head.eiid);
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (aw_pend_q && i_resp.aw_ready) aw_pend_d = 1'b0;
        if (w_pend_q && i_resp.w_ready)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)      state_d   = RESP;
      end
      RESP: begin
        if (i_resp.b_valid) begin
          state_d = IDLE;
          b_err   = (i_resp.b.resp != AXI_RESP_OKAY);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, beat payload and error pulse registers
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_q   <= IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= (push_fire && tgt_bad) || b_err;
      live_q    <= 1'b1;
    end
  end

  // AXI request drive; read channels stay idle
  always_comb begin
    o_req          = '0;
    o_req.aw_valid = aw_pend_q;
    o_req.aw.addr  = addr_q;
    o_req.aw.size  = 3'd2;
    o_req.aw.burst = 2'b01;
    o_req.w_valid  = w_pend_q;
    o_req.w.data   = data_q;
    o_req.w.strb   = WSTRB;
    o_req.w.last   = 1'b1;
    o_req.b_ready  = (state_q == RESP);
  end

endmodule

// File: tb/tb_aplic_msi_tx.sv
// Directed + random bench for aplic_msi_tx with an
// AXI write slave and a queue-based MSI address model.
module tb_aplic_msi_tx;
  import imsic_pkg::*;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          msi_valid = 1'b0;
  logic          msi_ready;
  logic [1:0]    hart = '0;
  logic [1:0]    file = '0;
  logic [10:0]   eiid = '0;
  axi_mst_req_t  req;
  axi_mst_resp_t resp;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  aplic_msi_tx dut (
    .i_clk       (clk),
    .ni_rst      (rst_n),
    .i_msi_valid (msi_valid),
    .o_msi_ready (msi_ready),
    .i_msi_hart  (hart),
    .i_msi_file  (file),
    .i_msi_eiid  (eiid),
    .o_req       (req),
    .i_resp      (resp),
    .o_busy      (busy),
    .o_err       (err)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [1:0] bresp_plan[$];
  int n_assert  = 0;
  int n_fail    = 0;
  int exp_err   = 0;
  int err_seen  = 0;
  int exp_total = 0;
  int aw_cnt    = 0;
  int w_cnt     = 0;
  int b_cnt     = 0;
  bit aw_rdy_en = 1'b1;
  bit w_rdy_en  = 1'b1;
  bit rnd_rdy   = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h",
             tag, obs, exp);
    end
  endtask

  // reference: what a request should turn into
  function automatic void model_push(int h, int f, int e);
    wr_t x;
    if (h >= 2 || f >= 3) begin
      exp_err++;
    end else if (e != 0) begin
      if (f == 0)
        x.addr = 64'h2400_0000 + 64'(h) * 64'h1000;
      else
        x.addr = 64'h2800_0000 + 64'(h * 2 + f - 1) * 64'h1000;
      x.data = 64'(e);
      exp_q.push_back(x);
      exp_total++;
    end
  endfunction

  task automatic send_msi(input int h, input int f, input int e);
    int t = 0;
    @(negedge clk);
    msi_valid = 1'b1;
    hart = 2'(h);
    file = 2'(f);
    eiid = 11'(e);
    while (!msi_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", 64'(t < 200), 1);
    @(posedge clk);
    #1 msi_valid = 1'b0;
    model_push(h, f, e);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || busy || resp.b_valid)
           && t < 500) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk({tag, "_drain_timeout"}, 64'(t < 500), 1);
    repeat (2) @(posedge clk);
    #2;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_count"}, err_seen, exp_err);
    chk({tag, "_aw_count"}, aw_cnt, exp_total);
  endtask

  // AXI write slave and monitor
  initial begin
    logic [63:0] got_a[$];
    logic [63:0] got_d[$];
    logic [7:0]  got_s[$];
    logic [63:0] hold_a;
    logic [63:0] hold_d;
    logic [1:0]  cur_resp;
    bit b_pend;
    bit aw_hold;
    bit w_hold;
    wr_t x;
    resp = '0;
    b_pend = 0;
    aw_hold = 0;
    w_hold = 0;
    hold_a = '0;
    hold_d = '0;
    cur_resp = 2'b00;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        got_a.delete();
        got_d.delete();
        got_s.delete();
        b_pend = 0;
        aw_hold = 0;
        w_hold = 0;
      end else begin
        if (err) err_seen++;
        if (aw_hold) begin
          chk("aw_hold_valid", req.aw_valid, 1);
          chk("aw_hold_addr", req.aw.addr, hold_a);
        end
        if (w_hold) begin
          chk("w_hold_valid", req.w_valid, 1);
          chk("w_hold_data", req.w.data, hold_d);
        end
        aw_hold = req.aw_valid && !resp.aw_ready;
        w_hold  = req.w_valid && !resp.w_ready;
        hold_a  = req.aw.addr;
        hold_d  = req.w.data;
        if (req.aw_valid && resp.aw_ready) begin
          chk("one_outstanding", 64'(aw_cnt - b_cnt), 0);
          chk("aw_len", req.aw.len, 0);
          chk("aw_size", req.aw.size, 2);
          chk("aw_prot", req.aw.prot, 0);
          chk("aw_id", req.aw.id, 0);
          aw_cnt++;
          got_a.push_back(req.aw.addr);
        end
        if (req.w_valid && resp.w_ready) begin
          chk("w_last", req.w.last, 1);
          w_cnt++;
          got_d.push_back(req.w.data);
          got_s.push_back(req.w.strb);
        end
        if (resp.b_valid && req.b_ready) begin
          b_cnt++;
          b_pend = 0;
        end
        if (!b_pend && got_a.size() != 0 && got_d.size() != 0) begin
          chk("write_expected", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk("aw_addr", got_a[0], x.addr);
            chk("w_data", got_d[0], x.data);
          end
          chk("w_strb", got_s[0], 8'h0F);
          void'(got_a.pop_front());
          void'(got_d.pop_front());
          void'(got_s.pop_front());
          b_pend = 1;
          if (bresp_plan.size() != 0) cur_resp = bresp_plan.pop_front();
          else cur_resp = 2'b00;
          if (cur_resp != 2'b00) exp_err++;
        end
      end
      #1;
      resp.aw_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : aw_rdy_en;
      resp.w_ready  = rnd_rdy ? 1'($urandom_range(0, 1)) : w_rdy_en;
      resp.b_valid  = b_pend && rst_n;
      resp.b.resp   = cur_resp;
    end
  end

  initial begin
    int t;
    int h;
    int f;
    int e;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_aw_valid", req.aw_valid, 0);
    chk("rst_w_valid", req.w_valid, 0);
    chk("rst_b_ready", req.b_ready, 0);
    chk("rst_ar_valid", req.ar_valid, 0);
    chk("rst_r_ready", req.r_ready, 0);
    chk("rst_msi_ready", msi_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_msi_ready", msi_ready, 1);
    chk("rel_busy", busy, 0);

    // single M-file MSI and issue latency
    send_msi(1, 0, 5);
    chk("lat_n1_aw", req.aw_valid, 0);
    chk("lat_n1_busy", busy, 1);
    @(posedge clk);
    #1;
    chk("lat_n2_aw", req.aw_valid, 1);
    chk("lat_n2_w", req.w_valid, 1);
    drain("m_file");

    // S file, AW accepted well before W
    w_rdy_en = 1'b0;
    send_msi(1, 2, 9);
    @(posedge clk);
    #1;
    chk("s_aw_valid", req.aw_valid, 1);
    @(posedge clk);
    #1;
    chk("s_aw_done", req.aw_valid, 0);
    chk("s_w_wait", req.w_valid, 1);
    repeat (2) @(posedge clk);
    #2 w_rdy_en = 1'b1;
    drain("s_file");

    // back-pressure: queue fills behind a stuck AW
    aw_rdy_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_msi(i % 2, i % 3, 16 + i);
      if (i == 3) chk("bp_ready_not_full", msi_ready, 1);
    end
    chk("bp_ready_full", msi_ready, 0);
    @(negedge clk);
    msi_valid = 1'b1;
    hart = 2'd0;
    file = 2'd1;
    eiid = 11'd30;
    repeat (3) @(negedge clk);
    chk("bp_ready_held_low", msi_ready, 0);
    aw_rdy_en = 1'b1;
    send_msi(0, 1, 30);
    drain("backpressure");

    // illegal targets and reserved identity
    send_msi(2, 0, 3);
    chk("bad_hart_err", err, 1);
    @(posedge clk);
    #1;
    chk("bad_hart_pulse_end", err, 0);
    send_msi(0, 3, 4);
    send_msi(1, 1, 0);
    drain("illegal");

    // slave error on B, next request still issues
    bresp_plan.push_back(2'b10);
    send_msi(0, 2, 11);
    send_msi(1, 0, 12);
    drain("slverr");

    // randomized requests and ready patterns
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      h = $urandom_range(0, 2);
      f = $urandom_range(0, 3);
      e = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2047);
      send_msi(h, f, e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain("random");
    rnd_rdy = 1'b0;

    // reset while a write is in flight
    aw_rdy_en = 1'b0;
    w_rdy_en  = 1'b0;
    send_msi(1, 1, 21);
    send_msi(0, 0, 22);
    t = 0;
    while (!req.aw_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("mid_reach_send", req.aw_valid, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mid_aw_drop", req.aw_valid, 0);
    chk("mid_w_drop", req.w_valid, 0);
    chk("mid_ready", msi_ready, 0);
    chk("mid_busy", busy, 0);
    exp_total -= exp_q.size();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    aw_rdy_en = 1'b1;
    w_rdy_en  = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", msi_ready, 1);
    chk("post_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_aw", req.aw_valid, 0);
    send_msi(0, 1, 23);
    drain("post_reset");

    chk("final_ar_valid", req.ar_valid, 0);
    chk("final_r_ready", req.r_ready, 0);
    chk("final_w_vs_aw", w_cnt, aw_cnt);
    chk("final_b_vs_aw", b_cnt, aw_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
